relu_stage_ctrl: RTL
====================

# relu_stage_ctrl

Frame-level controller for the activation stage between the convolution kernel output and the pooling/line buffers. It accepts a stream of signed conv results with a valid/ready handshake. It applies ReLU (or bypass) in a registered stage and buffers the results in a 2-entry FIFO. It tracks row/column position, flags end-of-line/end-of-frame, counts negative inputs, and signals frame completion.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH `` (16), pixel width, two's complement, sign = MSB
- `MAX_DIM`, 64, maximum feature-map rows/cols
- `CNT_W`, clog2(MAX_DIM+1), dimension/counter width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  frame start pulse, sampled only in IDLE
- `bypass`  in  1  1 = pass data unmodified, 0 = ReLU; captured at start
- `cfg_cols`  in  CNT_W  frame width, captured at start
- `cfg_rows`  in  CNT_W  frame height, captured at start
- `in_valid`  in  1  input pixel valid
- `in_ready`  out  1  input accept
- `in_data`  in  DATA_WIDTH  conv result
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  DATA_WIDTH  activated pixel
- `out_eol`  out  1  with out_valid: last column of a row
- `out_eof`  out  1  with out_valid: last pixel of frame
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle frame-complete pulse
- `neg_count`  out  2*CNT_W  negative inputs accepted this frame

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN: on start with cfg_cols≠0 and cfg_rows≠0. Captures bypass, cols, rows; clears col/row counters and neg_count.
  - IDLE→DONE: on start with either dimension 0. No data is accepted.
  - RUN→DRAIN: on the handshake of pixel cols*rows.
  - DRAIN→DONE: when the FIFO becomes empty (final output handshake leaves count 0).
  - DONE→IDLE: unconditionally after one cycle.
- start outside IDLE is ignored. Config inputs are don't-care except at start.
- in_ready = (state==RUN) && (fifo_count<2). It is derived from registered state only; there is no combinational path from out_ready.
- Input handshake (in_valid && in_ready):
  - Pixel is written to the FIFO with computed eol/eof tags.
  - col increments; on col==cols-1, col wraps to 0 and row increments.
  - neg_count increments if in_data MSB=1, in both modes.
- ReLU: MSB=0 → data unchanged; MSB=1 → 0. Examples: 0x8000→0, 0x0000→0x0000. Bypass passes data unchanged.
- FIFO: 2 entries, in order. Simultaneous push and pop is allowed at any count; count is unchanged when both occur.
- out_valid = fifo_count>0. out_data/eol/eof come from the FIFO head.
- in_valid while in_ready=0 is ignored and the data is not captured.
- out_eol and out_eof are both 1 on the final pixel.
- neg_count saturates at all-ones and holds until the next accepted start.
- Async reset mid-frame: FIFO emptied, state IDLE, partial frame discarded.
- Reset values: in_ready 0, out_valid 0, out_data 0, out_eol 0, out_eof 0, busy 0, done 0, neg_count 0.

## Timing
- Start accepted at edge t: busy=1 and in_ready=1 from t+1.
- Pixel accepted at edge t appears on out_data from t+1 (latency 1).
- Full throughput of 1 pixel/cycle while out_ready=1.
- out_ready low: at most 2 pixels are accepted. in_ready drops the cycle after count reaches 2, and returns the cycle after a pop.
- done is high for the cycle after the edge of the final output handshake. busy falls together with done.
- Zero-dimension start at t: done high at t+1, IDLE at t+2.

## Structure
- `` `DATA_WIDTH `` comes from global_define.v.
- State encodings and MAX_DIM/CNT_W go in a shared header, relu_stage_ctrl_param.v, for reuse by the pooling controller.
- One sub-module, act_skid_fifo: 2-entry FIFO of {eof, eol, data} with push/pop/count. FSM, counters and ReLU stay in the top.

## Test plan
- 2×3 frame, ReLU mode, out_ready=1, inputs 5, 0xFFFD, 0, 0x7FFF, 0x8000, 1:
  - Outputs 5, 0, 0, 0x7FFF, 0, 1.
  - out_eol on the 3rd and 6th pixel; out_eof on the 6th.
  - neg_count=2; done one cycle after the last handshake.
- Same frame in bypass mode → outputs identical to inputs, neg_count=2.
- 1×8 frame, out_ready held low for 5 cycles mid-frame:
  - Exactly 2 pixels are buffered and in_ready is 0.
  - After release, all 8 pixels arrive in order with no loss or duplication.
- start pulsed during RUN → ignored, counters unaffected. start with cfg_rows=0 → done at t+1, in_ready never 1.
- rst_n asserted after 3 of 6 pixels → all outputs at reset values immediately. A new 1×1 frame afterwards completes with neg_count from that frame only.
- 64×64 frame with random valid/ready gaps → 4096 outputs, one out_eof, 64 out_eol, matching a reference model.

Source files
------------

// File: rtl/relu_stage_ctrl_pkg.sv
// Shared constants and state encoding for the activation-stage controller,
// also used by the pooling controller.
package relu_stage_ctrl_pkg;

  localparam int unsigned RELU_DATA_WIDTH = 16;
  localparam int unsigned RELU_MAX_DIM    = 64;
  localparam int unsigned RELU_CNT_W      = $clog2(RELU_MAX_DIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/act_skid_fifo.sv
// Two-entry in-order FIFO holding tagged activation words; push and pop may
// coincide at any occupancy.
module act_skid_fifo #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/relu_stage_ctrl.sv
// Frame controller for the activation stage: ReLU/bypass, row/column tagging,
// negative-input counting and frame completion around a 2-entry output FIFO.
module relu_stage_ctrl
  import relu_stage_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RELU_DATA_WIDTH,
  parameter int unsigned MAX_DIM    = RELU_MAX_DIM,
  parameter int unsigned CNT_W      = $clog2(MAX_DIM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bypass,
  input  logic [CNT_W-1:0]      cfg_cols,
  input  logic [CNT_W-1:0]      cfg_rows,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  done,
  output logic [2*CNT_W-1:0]    neg_count
);

  state_e               state_q, state_d;
  logic                 byp_q, byp_d;
  logic [CNT_W-1:0]     cols_q, cols_d;
  logic [CNT_W-1:0]     rows_q, rows_d;
  logic [CNT_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic [2*CNT_W-1:0]   neg_q, neg_d;

  logic                 in_hs, out_hs;
  logic                 last_col, last_pix, in_neg;
  logic [DATA_WIDTH-1:0] act_data;
  logic [DATA_WIDTH+1:0] fifo_rdata;
  logic [1:0]           fifo_count;

  assign in_ready = (state_q == ST_RUN) && (fifo_count != 2'd2);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign in_neg   = in_data[DATA_WIDTH-1];
  assign last_col = (col_q == cols_q - CNT_W'(1));
  assign last_pix = last_col && (row_q == rows_q - CNT_W'(1));
  assign act_data = (byp_q || !in_neg) ? in_data : '0;

  always_comb begin
    state_d = state_q;
    byp_d   = byp_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    col_d   = col_q;
    row_d   = row_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_cols != '0 && cfg_rows != '0) begin
            state_d = ST_RUN;
            byp_d   = bypass;
            cols_d  = cfg_cols;
            rows_d  = cfg_rows;
            col_d   = '0;
            row_d   = '0;
            neg_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          if (in_neg && neg_q != '1) begin
            neg_d = neg_q + (2*CNT_W)'(1);
          end
          if (last_pix) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // No pushes happen here, so a pop at count 1 empties the FIFO.
        if (out_hs && fifo_count == 2'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      byp_q   <= 1'b0;
      cols_q  <= '0;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      byp_q   <= byp_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      col_q   <= col_d;
      row_q   <= row_d;
      neg_q   <= neg_d;
    end
  end

  act_skid_fifo #(
    .W(DATA_WIDTH + 2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_hs),
    .wdata ({last_pix, last_col, act_data}),
    .pop   (out_hs),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign out_valid                    = (fifo_count != 2'd0);
  assign {out_eof, out_eol, out_data} = fifo_rdata;
  assign busy                         = (state_q != ST_IDLE);
  assign done                         = (state_q == ST_DONE);
  assign neg_count                    = neg_q;

endmodule
